// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - opcodes, address map, IO offsets and load alignment for mem_access_ctrl
package mem_access_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int         DMEM_SEL_BIT = 28;
    localparam int         IMEM_SEL_BIT = 29;
    localparam logic [3:0] IO_REGION    = 4'b1000;

    localparam logic [7:0] IO_STATUS    = 8'h00;
    localparam logic [7:0] IO_RX_DATA   = 8'h04;
    localparam logic [7:0] IO_TX_DATA   = 8'h08;
    localparam logic [7:0] IO_CYCLE     = 8'h10;
    localparam logic [7:0] IO_CYCLE_CLR = 8'h18;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DMEM = 2'd1,
        SRC_IO   = 2'd2
    } ld_src_e;

    // Half selection uses only off[1], so odd halfword offsets fall back to the aligned half.
    function automatic logic [31:0] load_align(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'b0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request, response, memory and UART signals of mem_access_ctrl
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        fault;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [3:0]  imem_we;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_addr, req_wdata,
               dmem_rdata, tx_ready, rx_valid, rx_data,
        output req_ready, rsp_valid, rsp_data, fault, dmem_addr, dmem_we,
               dmem_wdata, imem_we, tx_valid, tx_data, rx_ready
    );

    modport master (
        output req_valid, req_opcode, req_funct3, req_addr, req_wdata,
               dmem_rdata, tx_ready, rx_valid, rx_data,
        input  req_ready, rsp_valid, rsp_data, fault, dmem_addr, dmem_we,
               dmem_wdata, imem_we, tx_valid, tx_data, rx_ready
    );
endinterface

// File: rtl/mem_access_ctrl_sync_fifo.sv
// rtl/mem_access_ctrl_sync_fifo.sv - synchronous FIFO with registered full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - data-side load/store controller for dmem, imem write port, UART and cycle counter
// Optional misaligned-access trapping: MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus
);
    logic [31:0] w_addr;
    logic [7:0]  w_io_off;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_hit_dmem;
    logic        w_hit_imem;
    logic        w_hit_io;
    logic        w_misalign;
    logic        w_ready;
    logic        w_accept;
    logic        w_st_en;
    logic        w_ld_acc;
    logic        w_push;
    logic        w_pop;
    logic        w_cnt_clr;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_head;
    logic [3:0]  w_mask;
    logic [31:0] w_st_data;
    logic [31:0] w_io_rdata;
    logic [31:0] w_cnt_ext;
    logic [31:0] w_rsp_data;
    ld_src_e     w_ld_src;

    logic             r_rsp_valid;
    logic             r_ld_fault;
    ld_src_e          r_ld_src;
    logic [1:0]       r_ld_off;
    logic [2:0]       r_ld_f3;
    logic [31:0]      r_io_data;
    logic [CNT_W-1:0] r_cnt;

    assign w_addr     = bus.req_addr;
    assign w_io_off   = w_addr[7:0];
    assign w_is_load  = (bus.req_opcode == OPC_LOAD);
    assign w_is_store = (bus.req_opcode == OPC_STORE);
    assign w_hit_dmem = !w_addr[31] && w_addr[DMEM_SEL_BIT];
    assign w_hit_imem = !w_addr[31] && w_addr[IMEM_SEL_BIT];
    assign w_hit_io   = (w_addr[31:28] == IO_REGION);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign w_misalign = (w_is_load || w_is_store) &&
                        (((bus.req_funct3[1:0] == 2'b01) && w_addr[0]) ||
                         ((bus.req_funct3 == F3_W) && (w_addr[1:0] != 2'b00)));
    assign bus.fault  = (w_accept && w_is_store && w_misalign) || r_ld_fault;
`else
    assign w_misalign = 1'b0;
    assign bus.fault  = 1'b0;
`endif

    // Full is the registered flag, so a pop in the same cycle does not release a blocked push.
    assign w_ready   = !(bus.req_valid && w_is_store && w_hit_io &&
                         (w_io_off == IO_TX_DATA) && w_fifo_full);
    assign w_accept  = bus.req_valid && w_ready;
    assign w_st_en   = w_accept && w_is_store && !w_misalign;
    assign w_ld_acc  = w_accept && w_is_load;
    assign w_push    = w_st_en && w_hit_io && (w_io_off == IO_TX_DATA);
    assign w_cnt_clr = w_st_en && w_hit_io && (w_io_off == IO_CYCLE_CLR);
    assign w_pop     = bus.tx_valid && bus.tx_ready;
    assign w_cnt_ext = 32'(r_cnt);

    always_comb begin
        w_mask    = 4'b1111;
        w_st_data = bus.req_wdata;
        case (bus.req_funct3)
            F3_B: begin
                w_mask    = 4'b0001 << w_addr[1:0];
                w_st_data = {4{bus.req_wdata[7:0]}};
            end
            F3_H: begin
                w_mask    = 4'b0011 << {w_addr[1], 1'b0};
                w_st_data = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_io_rdata = '0;
        case (w_io_off)
            IO_STATUS:  w_io_rdata = {30'b0, bus.rx_valid, !w_fifo_full};
            IO_RX_DATA: if (bus.rx_valid) w_io_rdata = {24'b0, bus.rx_data};
            IO_CYCLE:   w_io_rdata = w_cnt_ext;
            default:    ;
        endcase
    end

    always_comb begin
        w_ld_src = SRC_NONE;
        if (w_hit_dmem) begin
            w_ld_src = SRC_DMEM;
        end else if (w_hit_io) begin
            w_ld_src = SRC_IO;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.dmem_addr  = {w_addr[31:2], 2'b00};
    assign bus.dmem_wdata = w_st_data;
    assign bus.dmem_we    = (w_st_en && w_hit_dmem) ? w_mask : 4'b0000;
    assign bus.imem_we    = (w_st_en && w_hit_imem) ? w_mask : 4'b0000;
    assign bus.rx_ready   = w_ld_acc && !w_misalign && w_hit_io &&
                            (w_io_off == IO_RX_DATA) && bus.rx_valid;
    assign bus.tx_valid   = !w_fifo_empty;
    assign bus.tx_data    = w_fifo_head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (bus.req_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_ld_fault  <= 1'b0;
            r_ld_src    <= SRC_NONE;
            r_ld_off    <= 2'b00;
            r_ld_f3     <= 3'b000;
            r_io_data   <= '0;
        end else begin
            r_rsp_valid <= w_ld_acc;
            r_ld_fault  <= w_ld_acc && w_misalign;
            if (w_ld_acc) begin
                r_ld_src  <= w_ld_src;
                r_ld_off  <= w_addr[1:0];
                r_ld_f3   <= bus.req_funct3;
                r_io_data <= w_io_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_cnt_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A faulted load answers with zero regardless of its source.
    always_comb begin
        w_rsp_data = '0;
        if (r_rsp_valid && !r_ld_fault) begin
            case (r_ld_src)
                SRC_DMEM: w_rsp_data = load_align(bus.dmem_rdata, r_ld_off, r_ld_f3);
                SRC_IO:   w_rsp_data = r_io_data;
                default:  ;
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = w_rsp_data;
endmodule
